// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one data memory port between the core and an
// auxiliary (loader/debug) requester. One transaction is in flight at a time:
// IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> RESP, or IDLE -> RESP for a
// misaligned address, which never reaches the memory.
module dmem_arbiter #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  // Core requester
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  output logic [31:0]       c_rdata,
  output logic              c_ready,
  output logic              c_err,
  // Auxiliary requester
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [31:0]       a_wdata,
  output logic [31:0]       a_rdata,
  output logic              a_ready,
  output logic              a_err,
  // Memory port
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  // Status
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              last_q, last_d;    // 1 = aux was granted most recently
  logic              owner_q, owner_d;  // 1 = aux owns the current transaction
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              win;
  logic [ADDR_W-1:0] win_addr;

  // State and payload registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      last_q  <= 1'b1;  // core wins the first tie
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: arbitration and payload latch in IDLE, latency count in WAIT.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    win      = (c_req && a_req) ? ~last_q : a_req;
    win_addr = win ? a_addr : c_addr;
    unique case (state_q)
      StIdle: begin
        if (c_req || a_req) begin
          owner_d = win;
          last_d  = win;
          we_d    = win ? a_we : c_we;
          addr_d  = win_addr;
          wdata_d = win ? a_wdata : c_wdata;
          rdata_d = 32'd0;
          if (win_addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else begin
            err_d   = 1'b0;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = 3'(MEM_LATENCY - 1);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          rdata_d = we_q ? 32'd0 : m_rdata;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StResp: begin
        rdata_d = 32'd0;
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from registered state only, so reset clears them at once.
  always_comb begin
    busy     = (state_q != StIdle);
    grant_id = busy & owner_q;
    m_en     = (state_q == StIssue);
    m_we     = m_en & we_q;
    m_addr   = m_en ? addr_q : '0;
    m_wdata  = m_en ? wdata_q : 32'd0;
    c_ready  = (state_q == StResp) & ~owner_q;
    a_ready  = (state_q == StResp) & owner_q;
    c_err    = c_ready & err_q;
    a_err    = a_ready & err_q;
    c_rdata  = c_ready ? rdata_q : 32'd0;
    a_rdata  = a_ready ? rdata_q : 32'd0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed accesses push expected responses
// and memory issues into queues; negedge monitors pop and compare.
module tb_dmem_arbiter;

  localparam logic [31:0] Key = 32'hA5A5_0000;

  typedef struct {logic side; logic [31:0] rdata; logic err; int cyc;} rsp_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic gid; int cyc;} mem_t;

  logic clk = 1'b0;
  logic reset;
  logic c_req, c_we, a_req, a_we;
  logic [31:0] c_addr, c_wdata, a_addr, a_wdata;
  logic [31:0] c_rdata, a_rdata, m_addr, m_wdata, m_rdata;
  logic c_ready, c_err, a_ready, a_err, m_en, m_we, busy, grant_id;

  // Second instance with MEM_LATENCY=3
  logic c3_req;
  logic [31:0] c3_addr;
  logic [31:0] c3_rdata, a3_rdata, m3_addr, m3_wdata, m3_rdata;
  logic c3_ready, c3_err, a3_ready, a3_err, m3_en, m3_we, busy3, gid3;
  logic zero1 = 1'b0;
  logic [31:0] zero32 = 32'd0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n;
  rsp_t rq[$];
  rsp_t rq3[$];
  mem_t mq[$];

  dmem_arbiter #(.MEM_LATENCY(1), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ready(c_ready), .c_err(c_err),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ready(a_ready), .a_err(a_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  dmem_arbiter #(.MEM_LATENCY(3), .ADDR_W(32)) dut3 (
    .clk(clk), .reset(reset),
    .c_req(c3_req), .c_we(zero1), .c_addr(c3_addr), .c_wdata(zero32),
    .c_rdata(c3_rdata), .c_ready(c3_ready), .c_err(c3_err),
    .a_req(zero1), .a_we(zero1), .a_addr(zero32), .a_wdata(zero32),
    .a_rdata(a3_rdata), .a_ready(a3_ready), .a_err(a3_err),
    .m_en(m3_en), .m_we(m3_we), .m_addr(m3_addr), .m_wdata(m3_wdata), .m_rdata(m3_rdata),
    .busy(busy3), .grant_id(gid3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: read data is valid only in cycle (enable cycle + latency).
  int k1 = 0;
  int k3 = 0;
  logic [31:0] a1_l = 32'd0;
  always @(posedge clk) begin
    if (m_en) begin
      k1 <= 1;
      a1_l <= m_addr;
    end else if (k1 != 0 && k1 < 100) k1 <= k1 + 1;
    if (m3_en) k3 <= 1;
    else if (k3 != 0 && k3 < 100) k3 <= k3 + 1;
  end
  assign m_rdata  = (k1 == 1) ? (a1_l ^ Key) : 32'hBAD0_BAD0;
  assign m3_rdata = (k3 == 3) ? 32'hDEAD_BEEF : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_r(logic side, logic [31:0] rd, logic err, int c);
    rsp_t r;
    r.side = side; r.rdata = rd; r.err = err; r.cyc = c;
    rq.push_back(r);
  endfunction

  function automatic void push_m(logic we, logic [31:0] addr, logic [31:0] wd, logic gid, int c);
    mem_t m;
    m.we = we; m.addr = addr; m.wdata = wd; m.gid = gid; m.cyc = c;
    mq.push_back(m);
  endfunction

  // Response monitor
  always @(negedge clk) begin
    rsp_t r;
    if (c_ready || a_ready) begin
      if (rq.size() == 0) chk("unexpected_ready", {c_ready, a_ready}, 2'b00);
      else begin
        r = rq.pop_front();
        chk("ready_side", {c_ready, a_ready}, r.side ? 2'b01 : 2'b10);
        chk("ready_cycle", cyc, r.cyc);
        chk("rdata", r.side ? a_rdata : c_rdata, r.rdata);
        chk("err", r.side ? a_err : c_err, r.err);
        chk("nonowner_quiet", r.side ? {c_rdata, c_err} : {a_rdata, a_err}, 0);
      end
    end else begin
      chk("idle_resp_quiet", {c_rdata, a_rdata, c_err, a_err}, 0);
    end
  end

  // Memory-side monitor
  always @(negedge clk) begin
    mem_t m;
    if (m_en) begin
      if (mq.size() == 0) chk("unexpected_m_en", m_en, 1'b0);
      else begin
        m = mq.pop_front();
        chk("m_en_cycle", cyc, m.cyc);
        chk("m_fields", {m_we, m_addr, m_wdata}, {m.we, m.addr, m.wdata});
        chk("grant_busy", {grant_id, busy}, {m.gid, 1'b1});
      end
    end else begin
      chk("m_quiet", {m_we, m_addr, m_wdata}, 0);
      if (!busy) chk("gid_idle", grant_id, 1'b0);
    end
  end

  // Monitor for the latency-3 instance
  always @(negedge clk) begin
    rsp_t r;
    if (c3_ready || a3_ready) begin
      if (rq3.size() == 0) chk("lat3_unexpected_ready", {c3_ready, a3_ready}, 2'b00);
      else begin
        r = rq3.pop_front();
        chk("lat3_side", {c3_ready, a3_ready}, 2'b10);
        chk("lat3_cycle", cyc, r.cyc);
        chk("lat3_rdata", c3_rdata, r.rdata);
      end
    end
  end

  function automatic logic [135:0] all_outs();
    return {c_rdata, c_ready, c_err, a_rdata, a_ready, a_err,
            m_en, m_we, m_addr, m_wdata, busy, grant_id};
  endfunction

  // Raise a request and hold it until ready; 'drop' releases it afterwards.
  task automatic acc(input logic side, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic drop);
    logic got;
    if (side) begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
    else begin c_req = 1; c_we = we; c_addr = addr; c_wdata = wdata; end
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!got) begin
        @(negedge clk);
        got = side ? a_ready : c_ready;
      end
    end
    if (!got) chk("ready_timeout", 1'b0, 1'b1);
    if (drop) begin
      if (side) begin a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0; end
      else begin c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; end
    end
  endtask

  task automatic pulse_reset(input string name);
    #1 reset = 1'b0;
    #1 chk(name, {all_outs(), c3_ready, busy3, m3_en}, 0);
    #1 reset = 1'b1;
  endtask

  initial begin
    logic got;
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    c3_req = 0; c3_addr = 0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2 chk("reset_outputs", {all_outs(), c3_ready, busy3, m3_en}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Core write, addr 100 data 7
    n = cyc;
    push_m(1, 100, 7, 0, n + 1);
    push_r(0, 0, 0, n + 3);
    acc(0, 1, 100, 7, 1);
    repeat (2) @(negedge clk);

    // Request dropped and payload changed after latching: no effect
    n = cyc;
    push_m(1, 200, 5, 0, n + 1);
    push_r(0, 0, 0, n + 3);
    c_req = 1; c_we = 1; c_addr = 200; c_wdata = 5;
    @(negedge clk);
    c_req = 0; c_we = 0; c_addr = 204; c_wdata = 9;
    repeat (4) @(negedge clk);
    c_addr = 0; c_wdata = 0;

    // Simultaneous first requests after reset: core first, aux 4 cycles later
    @(negedge clk);
    pulse_reset("reset_idle_outputs");
    @(negedge clk);
    n = cyc;
    push_m(0, 8, 0, 0, n + 1);
    push_r(0, 32'd8 ^ Key, 0, n + 3);
    push_m(0, 12, 0, 1, n + 5);
    push_r(1, 32'd12 ^ Key, 0, n + 7);
    fork
      acc(0, 0, 8, 0, 1);
      acc(1, 0, 12, 0, 1);
    join
    repeat (2) @(negedge clk);

    // Continuous back-to-back reads from both: grants alternate
    n = cyc;
    push_m(0, 16, 0, 0, n + 1);  push_r(0, 32'd16 ^ Key, 0, n + 3);
    push_m(0, 32, 0, 1, n + 5);  push_r(1, 32'd32 ^ Key, 0, n + 7);
    push_m(0, 20, 0, 0, n + 9);  push_r(0, 32'd20 ^ Key, 0, n + 11);
    push_m(0, 36, 0, 1, n + 13); push_r(1, 32'd36 ^ Key, 0, n + 15);
    push_m(0, 24, 0, 0, n + 17); push_r(0, 32'd24 ^ Key, 0, n + 19);
    push_m(0, 40, 0, 1, n + 21); push_r(1, 32'd40 ^ Key, 0, n + 23);
    fork
      begin acc(0, 0, 16, 0, 0); acc(0, 0, 20, 0, 0); acc(0, 0, 24, 0, 1); end
      begin acc(1, 0, 32, 0, 0); acc(1, 0, 36, 0, 0); acc(1, 0, 40, 0, 1); end
    join
    repeat (2) @(negedge clk);

    // Misaligned accesses: immediate error response, no memory enable
    n = cyc;
    push_r(1, 0, 1, n + 1);
    acc(1, 0, 32'h62, 0, 1);
    repeat (2) @(negedge clk);
    n = cyc;
    push_r(0, 0, 1, n + 1);
    acc(0, 1, 32'h101, 32'h55, 1);
    repeat (2) @(negedge clk);

    // Reset pulse during WAIT drops the access; a later read completes
    n = cyc;
    push_m(0, 40, 0, 0, n + 1);
    c_req = 1; c_we = 0; c_addr = 40; c_wdata = 0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    #1 chk("reset_mid_wait", all_outs(), 0);
    c_req = 0; c_addr = 0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    n = cyc;
    push_m(0, 96, 0, 0, n + 1);
    push_r(0, 32'd96 ^ Key, 0, n + 3);
    acc(0, 0, 96, 0, 1);
    repeat (2) @(negedge clk);

    // Latency-3 instance: ready in cycle 5 with memory data
    n = cyc;
    begin
      rsp_t r;
      r.side = 0; r.rdata = 32'hDEAD_BEEF; r.err = 0; r.cyc = n + 5;
      rq3.push_back(r);
    end
    c3_req = 1; c3_addr = 0;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!got) begin
        @(negedge clk);
        got = c3_ready;
      end
    end
    if (!got) chk("lat3_timeout", 1'b0, 1'b1);
    c3_req = 0;

    repeat (4) @(negedge clk);
    chk("rsp_queue_drained", rq.size(), 0);
    chk("mem_queue_drained", mq.size(), 0);
    chk("lat3_queue_drained", rq3.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
